// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache definitions: line geometry defaults and the memory-arbiter state encoding.
package cache_mem_arbiter_pkg;

    localparam int unsigned CACHE_ADDR_W = 32;
    localparam int unsigned CACHE_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ICACHE = 2'd1,
        ARB_DCACHE = 2'd2,
        ARB_DRAIN  = 2'd3
    } type_arb_states_e;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter serialising icache fills and dcache allocates/write-backs onto
// the single main-memory line port; a withdrawn request is drained, never abandoned.
module cache_mem_arbiter
    import cache_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = CACHE_ADDR_W,
    parameter int unsigned LINE_W = CACHE_LINE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              icache2arb_req_i,
    input  logic [ADDR_W-1:0] icache2arb_addr_i,
    output logic              arb2icache_ack_o,
    output logic [LINE_W-1:0] arb2icache_data_o,
    input  logic              dcache2arb_req_i,
    input  logic              dcache2arb_wr_i,
    input  logic [ADDR_W-1:0] dcache2arb_addr_i,
    input  logic [LINE_W-1:0] dcache2arb_wdata_i,
    output logic              arb2dcache_ack_o,
    output logic [LINE_W-1:0] arb2dcache_data_o,
    output logic              arb2mem_req_o,
    output logic              arb2mem_wr_o,
    output logic [ADDR_W-1:0] arb2mem_addr_o,
    output logic [LINE_W-1:0] arb2mem_wdata_o,
    input  logic              mem2arb_ack_i,
    input  logic [LINE_W-1:0] mem2arb_rdata_i
);

    type_arb_states_e  state_ff, state_nxt;
    logic              last_dcache_ff, last_dcache_nxt;
    logic              owner_dcache_ff, owner_dcache_nxt;
    logic              mem_req_nxt, mem_wr_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [LINE_W-1:0] mem_wdata_nxt;
    logic              owner_req;

    // Read data is a straight wire; consumers qualify it with their ack.
    assign arb2icache_data_o = mem2arb_rdata_i;
    assign arb2dcache_data_o = mem2arb_rdata_i;

    assign owner_req = owner_dcache_ff ? dcache2arb_req_i : icache2arb_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_ff        <= ARB_IDLE;
            last_dcache_ff  <= 1'b0;
            owner_dcache_ff <= 1'b0;
            arb2mem_req_o   <= 1'b0;
            arb2mem_wr_o    <= 1'b0;
            arb2mem_addr_o  <= '0;
            arb2mem_wdata_o <= '0;
        end else begin
            state_ff        <= state_nxt;
            last_dcache_ff  <= last_dcache_nxt;
            owner_dcache_ff <= owner_dcache_nxt;
            arb2mem_req_o   <= mem_req_nxt;
            arb2mem_wr_o    <= mem_wr_nxt;
            arb2mem_addr_o  <= mem_addr_nxt;
            arb2mem_wdata_o <= mem_wdata_nxt;
        end
    end

    always_comb begin
        state_nxt        = state_ff;
        last_dcache_nxt  = last_dcache_ff;
        owner_dcache_nxt = owner_dcache_ff;
        mem_req_nxt      = arb2mem_req_o;
        mem_wr_nxt       = arb2mem_wr_o;
        mem_addr_nxt     = arb2mem_addr_o;
        mem_wdata_nxt    = arb2mem_wdata_o;
        arb2icache_ack_o = 1'b0;
        arb2dcache_ack_o = 1'b0;

        unique case (state_ff)
            ARB_IDLE: begin
                // On a tie the requester not served last wins.
                if (dcache2arb_req_i && (!icache2arb_req_i || !last_dcache_ff)) begin
                    state_nxt        = ARB_DCACHE;
                    owner_dcache_nxt = 1'b1;
                    mem_req_nxt      = 1'b1;
                    mem_wr_nxt       = dcache2arb_wr_i;
                    mem_addr_nxt     = dcache2arb_addr_i;
                    mem_wdata_nxt    = dcache2arb_wdata_i;
                end else if (icache2arb_req_i) begin
                    state_nxt        = ARB_ICACHE;
                    owner_dcache_nxt = 1'b0;
                    mem_req_nxt      = 1'b1;
                    mem_wr_nxt       = 1'b0;
                    mem_addr_nxt     = icache2arb_addr_i;
                    mem_wdata_nxt    = '0;
                end
            end
            ARB_ICACHE, ARB_DCACHE: begin
                if (mem2arb_ack_i) begin
                    arb2icache_ack_o = (state_ff == ARB_ICACHE);
                    arb2dcache_ack_o = (state_ff == ARB_DCACHE);
                    last_dcache_nxt  = owner_dcache_ff;
                    mem_req_nxt      = 1'b0;
                    state_nxt        = ARB_IDLE;
                end else if (!owner_req) begin
                    state_nxt = ARB_DRAIN;
                end
            end
            ARB_DRAIN: begin
                // Memory cannot be cancelled, so wait out the ack and swallow it.
                if (mem2arb_ack_i) begin
                    last_dcache_nxt = owner_dcache_ff;
                    mem_req_nxt     = 1'b0;
                    state_nxt       = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: queue-driven requesters, latency-programmable memory model
// and a scoreboard of expected memory transactions checked cycle by cycle.
module tb_cache_mem_arbiter;
    import cache_mem_arbiter_pkg::*;

    localparam int unsigned AW = CACHE_ADDR_W;
    localparam int unsigned LW = CACHE_LINE_W;
    localparam logic [LW-1:0] RD_LINE = {4{32'hA5A5_A5A5}};
    localparam logic [LW-1:0] WB_LINE = {4{32'hDEAD_BEEF}};

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          icache2arb_req_i, dcache2arb_req_i, dcache2arb_wr_i;
    logic [AW-1:0] icache2arb_addr_i, dcache2arb_addr_i;
    logic [LW-1:0] dcache2arb_wdata_i;
    logic          arb2icache_ack_o, arb2dcache_ack_o;
    logic [LW-1:0] arb2icache_data_o, arb2dcache_data_o;
    logic          arb2mem_req_o, arb2mem_wr_o;
    logic [AW-1:0] arb2mem_addr_o;
    logic [LW-1:0] arb2mem_wdata_o;
    logic          mem2arb_ack_i;
    logic [LW-1:0] mem2arb_rdata_i;

    cache_mem_arbiter dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .icache2arb_req_i   (icache2arb_req_i),
        .icache2arb_addr_i  (icache2arb_addr_i),
        .arb2icache_ack_o   (arb2icache_ack_o),
        .arb2icache_data_o  (arb2icache_data_o),
        .dcache2arb_req_i   (dcache2arb_req_i),
        .dcache2arb_wr_i    (dcache2arb_wr_i),
        .dcache2arb_addr_i  (dcache2arb_addr_i),
        .dcache2arb_wdata_i (dcache2arb_wdata_i),
        .arb2dcache_ack_o   (arb2dcache_ack_o),
        .arb2dcache_data_o  (arb2dcache_data_o),
        .arb2mem_req_o      (arb2mem_req_o),
        .arb2mem_wr_o       (arb2mem_wr_o),
        .arb2mem_addr_o     (arb2mem_addr_o),
        .arb2mem_wdata_o    (arb2mem_wdata_o),
        .mem2arb_ack_i      (mem2arb_ack_i),
        .mem2arb_rdata_i    (mem2arb_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } rq_t;

    typedef struct {
        logic          dc;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic          acked;
        int            lat;
    } txn_t;

    typedef struct {
        logic          dc;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        int            lat;
        logic          exp_wr;
        logic [LW-1:0] exp_wdata;
    } vec_t;

    rq_t  iq[$];
    rq_t  dq[$];
    txn_t exp_q[$];
    txn_t cur;
    logic have_cur = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   mem_lat = 3;
    logic spur_ack = 1'b0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_i(input logic [AW-1:0] a, input int lat, input logic acked);
        rq_t  r;
        txn_t t;
        r.wr = 1'b0; r.addr = a; r.wdata = '0;
        iq.push_back(r);
        t.dc = 1'b0; t.wr = 1'b0; t.addr = a; t.wdata = '0; t.acked = acked; t.lat = lat;
        exp_q.push_back(t);
    endtask

    task automatic push_d(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                          input int lat, input logic acked);
        rq_t  r;
        txn_t t;
        r.wr = wr; r.addr = a; r.wdata = wd;
        dq.push_back(r);
        t.dc = 1'b1; t.wr = wr; t.addr = a; t.wdata = wd; t.acked = acked; t.lat = lat;
        exp_q.push_back(t);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((iq.size() > 0 || dq.size() > 0 || exp_q.size() > 0 || have_cur || arb2mem_req_o)
               && n < 300) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk({name, "_completed"}, LW'(n < 300), LW'(1));
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (!arb2mem_req_o && n < 50) begin
            @(posedge clk_i); #2;
            n++;
        end
        chk({name, "_req_seen"}, LW'(arb2mem_req_o), LW'(1));
    endtask

    // Memory: acks on the lat-th cycle of a request; optional stray ack while idle.
    initial begin
        int cnt;
        cnt = 0;
        mem2arb_ack_i = 1'b0;
        mem2arb_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            if (rst_i) begin
                mem2arb_ack_i = 1'b0; cnt = 0;
            end else if (!arb2mem_req_o) begin
                mem2arb_ack_i = spur_ack; cnt = 0;
            end else begin
                mem2arb_ack_i = (cnt == mem_lat - 1);
                cnt++;
            end
            mem2arb_rdata_i = mem2arb_ack_i ? RD_LINE : '0;
        end
    end

    // Requesters: hold the head of each queue until its ack is seen.
    initial begin
        icache2arb_req_i = 1'b0; icache2arb_addr_i = '0;
        dcache2arb_req_i = 1'b0; dcache2arb_wr_i = 1'b0;
        dcache2arb_addr_i = '0;  dcache2arb_wdata_i = '0;
        forever begin
            @(negedge clk_i);
            if (arb2icache_ack_o && iq.size() > 0) iq.delete(0);
            if (arb2dcache_ack_o && dq.size() > 0) dq.delete(0);
            icache2arb_req_i = (iq.size() > 0);
            dcache2arb_req_i = (dq.size() > 0);
            if (iq.size() > 0) icache2arb_addr_i = iq[0].addr;
            if (dq.size() > 0) begin
                dcache2arb_wr_i    = dq[0].wr;
                dcache2arb_addr_i  = dq[0].addr;
                dcache2arb_wdata_i = dq[0].wdata;
            end
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    logic req_q = 1'b0;
    logic done_q = 1'b0;
    int   hi_cnt = 0;
    logic exp_ia, exp_da;
    always @(negedge clk_i) begin
        if (rst_i) begin
            have_cur = 1'b0; req_q = 1'b0; done_q = 1'b0; hi_cnt = 0;
        end else begin
            if (done_q) chk("req_drop_after_ack", LW'(arb2mem_req_o), LW'(0));
            if (arb2mem_req_o && !req_q) begin
                hi_cnt = 0;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_grant: addr %0h got a grant, expected none", arb2mem_addr_o);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                end
            end
            if (arb2mem_req_o) hi_cnt++;
            if (arb2mem_req_o && have_cur) begin
                chk("mem_wr", LW'(arb2mem_wr_o), LW'(cur.wr));
                chk("mem_addr", LW'(arb2mem_addr_o), LW'(cur.addr));
                chk("mem_wdata", arb2mem_wdata_o, cur.wdata);
            end
            exp_ia = mem2arb_ack_i && arb2mem_req_o && have_cur && cur.acked && !cur.dc;
            exp_da = mem2arb_ack_i && arb2mem_req_o && have_cur && cur.acked && cur.dc;
            chk("icache_ack", LW'(arb2icache_ack_o), LW'(exp_ia));
            chk("dcache_ack", LW'(arb2dcache_ack_o), LW'(exp_da));
            if (arb2icache_ack_o) chk("icache_data", arb2icache_data_o, RD_LINE);
            if (arb2dcache_ack_o) chk("dcache_data", arb2dcache_data_o, RD_LINE);
            done_q = mem2arb_ack_i && arb2mem_req_o;
            if (done_q && have_cur) begin
                chk("mem_req_cycles", LW'(hi_cnt), LW'(cur.lat));
                have_cur = 1'b0;
            end
            req_q = arb2mem_req_o;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        rq_t  r;
        txn_t t;

        vecs[0] = '{dc: 1'b0, wr: 1'b0, addr: 32'h0000_0100, wdata: '0, lat: 3,
                    exp_wr: 1'b0, exp_wdata: '0};
        vecs[1] = '{dc: 1'b1, wr: 1'b1, addr: 32'h0000_2040, wdata: WB_LINE, lat: 4,
                    exp_wr: 1'b1, exp_wdata: WB_LINE};
        vecs[2] = '{dc: 1'b1, wr: 1'b0, addr: 32'h0000_3000, wdata: {4{32'h1234_5678}}, lat: 1,
                    exp_wr: 1'b0, exp_wdata: {4{32'h1234_5678}}};
        vecs[3] = '{dc: 1'b0, wr: 1'b0, addr: 32'hFFFF_FFC0, wdata: '0, lat: 2,
                    exp_wr: 1'b0, exp_wdata: '0};
        vecs[4] = '{dc: 1'b1, wr: 1'b1, addr: 32'h0000_0000, wdata: '1, lat: 6,
                    exp_wr: 1'b1, exp_wdata: '1};

        // Reset state.
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #2;
        chk("rst_mem_req", LW'(arb2mem_req_o), LW'(0));
        chk("rst_mem_wr", LW'(arb2mem_wr_o), LW'(0));
        chk("rst_mem_addr", LW'(arb2mem_addr_o), LW'(0));
        chk("rst_mem_wdata", arb2mem_wdata_o, '0);
        chk("rst_iack", LW'(arb2icache_ack_o), LW'(0));
        chk("rst_dack", LW'(arb2dcache_ack_o), LW'(0));
        rst_i = 1'b0;

        // First tie after reset goes to dcache; held requests then alternate D, I, D, I.
        mem_lat = 2;
        push_d(1'b1, 32'h0000_1000, WB_LINE, 2, 1'b1);
        push_i(32'h0000_0200, 2, 1'b1);
        push_d(1'b0, 32'h0000_1040, {4{32'h0BAD_F00D}}, 2, 1'b1);
        push_i(32'h0000_0240, 2, 1'b1);
        wait_done("alternate");

        // Single-requester transactions from the table.
        for (int k = 0; k < 5; k++) begin
            mem_lat = vecs[k].lat;
            r.wr = vecs[k].wr; r.addr = vecs[k].addr; r.wdata = vecs[k].wdata;
            t.dc = vecs[k].dc; t.wr = vecs[k].exp_wr; t.addr = vecs[k].addr;
            t.wdata = vecs[k].exp_wdata; t.acked = 1'b1; t.lat = vecs[k].lat;
            if (vecs[k].dc) dq.push_back(r);
            else            iq.push_back(r);
            exp_q.push_back(t);
            wait_done($sformatf("vec%0d", k));
        end

        // Dcache withdraws one cycle in: drained silently, pending icache follows.
        mem_lat = 5;
        push_d(1'b0, 32'h0000_4000, {4{32'h5555_AAAA}}, 5, 1'b0);
        wait_req("drain");
        dq.delete();
        push_i(32'h0000_0400, 5, 1'b1);
        wait_done("drain");

        // Spurious memory ack while idle.
        @(posedge clk_i); #2;
        spur_ack = 1'b1;
        @(posedge clk_i); #2;
        spur_ack = 1'b0;
        chk("spur_mem_ack_seen", LW'(mem2arb_ack_i), LW'(1));
        chk("spur_iack", LW'(arb2icache_ack_o), LW'(0));
        chk("spur_dack", LW'(arb2dcache_ack_o), LW'(0));
        @(posedge clk_i); #2;
        chk("spur_mem_req", LW'(arb2mem_req_o), LW'(0));
        chk("spur_state", LW'(dut.state_ff), LW'(ARB_IDLE));
        mem_lat = 2;
        push_i(32'h0000_0800, 2, 1'b1);
        wait_done("after_spur");

        // Reset mid-icache transaction aborts; next tie goes to dcache.
        mem_lat = 10;
        push_i(32'h0000_0500, 10, 1'b1);
        wait_req("rst_mid");
        repeat (2) begin @(posedge clk_i); #2; end
        rst_i = 1'b1;
        iq.delete();
        @(posedge clk_i); #2;
        chk("rst_mid_mem_req", LW'(arb2mem_req_o), LW'(0));
        chk("rst_mid_iack", LW'(arb2icache_ack_o), LW'(0));
        chk("rst_mid_dack", LW'(arb2dcache_ack_o), LW'(0));
        chk("rst_mid_state", LW'(dut.state_ff), LW'(ARB_IDLE));
        rst_i = 1'b0;
        mem_lat = 2;
        push_d(1'b1, 32'h0000_6000, WB_LINE, 2, 1'b1);
        push_i(32'h0000_0600, 2, 1'b1);
        wait_done("tie_after_rst");

        repeat (3) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
